// File: rtl/axi_reg_slice_pkg.sv
// Shared types and field widths for the AXI register slice.
package axi_reg_slice_pkg;

   typedef enum logic [1:0] {
      SLICE_BYPASS = 2'd0,
      SLICE_FWD    = 2'd1,
      SLICE_FULL   = 2'd2
   } slice_mode_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'd0,
      RESP_EXOKAY = 2'd1,
      RESP_SLVERR = 2'd2,
      RESP_DECERR = 2'd3
   } resp_e;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2,
      BURST_RSVD  = 2'd3
   } burst_e;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_FULL  = 2'd2
   } skid_state_e;

   localparam int unsigned AXI_SIZE_W = 3;
   localparam int unsigned BURST_W    = 2;
   localparam int unsigned LOCK_W     = 1;
   localparam int unsigned CACHE_W    = 4;
   localparam int unsigned PROT_W     = 3;
   localparam int unsigned RESP_W     = 2;

   // Packed width of an AW/AR payload: id, addr, len, size, burst, lock, cache, prot.
   function automatic int unsigned ax_payload_w(int unsigned id_w, int unsigned addr_w,
                                                int unsigned len_w);
      return id_w + addr_w + len_w + AXI_SIZE_W + BURST_W + LOCK_W + CACHE_W + PROT_W;
   endfunction

endpackage

// File: rtl/axi_reg_slice_ch.sv
// Generic valid/ready slice on a packed payload: bypass, forward register or 2-entry skid buffer.
module axi_reg_slice_ch
   import axi_reg_slice_pkg::*;
#(
   parameter int unsigned PAYLOAD_W = 8,
   parameter int unsigned MODE      = 2
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic                 src_valid,
   output logic                 src_ready,
   input  logic [PAYLOAD_W-1:0] src_data,
   output logic                 dst_valid,
   input  logic                 dst_ready,
   output logic [PAYLOAD_W-1:0] dst_data
);

   generate
      if (MODE == 32'(SLICE_BYPASS)) begin : g_bypass
         logic unused_clk_rst;
         assign unused_clk_rst = &{1'b0, aclk, areset};
         assign dst_valid      = src_valid;
         assign src_ready      = dst_ready;
         assign dst_data       = src_data;
      end else if (MODE == 32'(SLICE_FWD)) begin : g_fwd
         logic                 v_q;
         logic [PAYLOAD_W-1:0] data_q;

         // Ready is combinational: the stage frees up in the same cycle it drains.
         assign src_ready = !v_q || dst_ready;
         assign dst_valid = v_q;
         assign dst_data  = data_q;

         always_ff @(posedge aclk) begin
            if (areset)         v_q <= 1'b0;
            else if (src_ready) v_q <= src_valid;
         end

         always_ff @(posedge aclk) begin
            if (src_ready && src_valid) data_q <= src_data;
         end
      end else if (MODE == 32'(SLICE_FULL)) begin : g_full
         skid_state_e          state_q, state_d;
         logic                 ready_q, valid_q;
         logic [PAYLOAD_W-1:0] head_q, skid_q;
         logic                 push, pop, load_head, head_from_skid, load_skid;

         assign push      = src_valid && ready_q;
         assign pop       = valid_q && dst_ready;
         assign src_ready = ready_q;
         assign dst_valid = valid_q;
         assign dst_data  = head_q;

         // Ready and valid are flops decoded from the next state, so neither path is combinational.
         always_ff @(posedge aclk) begin
            if (areset) begin
               state_q <= SKID_EMPTY;
               ready_q <= 1'b0;
               valid_q <= 1'b0;
            end else begin
               state_q <= state_d;
               ready_q <= (state_d != SKID_FULL);
               valid_q <= (state_d != SKID_EMPTY);
            end
         end

         always_comb begin
            state_d        = state_q;
            load_head      = 1'b0;
            head_from_skid = 1'b0;
            load_skid      = 1'b0;
            unique case (state_q)
               SKID_EMPTY: begin
                  if (push) begin
                     state_d   = SKID_ONE;
                     load_head = 1'b1;
                  end
               end
               SKID_ONE: begin
                  if (push && !pop) begin
                     state_d   = SKID_FULL;
                     load_skid = 1'b1;
                  end else if (push && pop) begin
                     load_head = 1'b1;
                  end else if (pop) begin
                     state_d = SKID_EMPTY;
                  end
               end
               SKID_FULL: begin
                  if (pop) begin
                     state_d        = SKID_ONE;
                     load_head      = 1'b1;
                     head_from_skid = 1'b1;
                  end
               end
               default: state_d = SKID_EMPTY;
            endcase
         end

         always_ff @(posedge aclk) begin
            if (load_head) head_q <= head_from_skid ? skid_q : src_data;
            if (load_skid) skid_q <= src_data;
         end
      end else begin : g_bad
         logic unused_in;
         assign unused_in = &{1'b0, aclk, areset, src_valid, dst_ready, src_data};
         assign dst_valid = 1'b0;
         assign src_ready = 1'b0;
         assign dst_data  = '0;
         $error("axi_reg_slice_ch: illegal MODE %0d", MODE);
      end
   endgenerate

endmodule

// File: rtl/axi_reg_slice.sv
// Five-channel AXI register slice; each channel packs its fields into one axi_reg_slice_ch.
module axi_reg_slice
   import axi_reg_slice_pkg::*;
#(
   parameter int unsigned ID_W    = 4,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned LEN_W   = 8,
   parameter int unsigned AW_MODE = 2,
   parameter int unsigned W_MODE  = 2,
   parameter int unsigned B_MODE  = 1,
   parameter int unsigned AR_MODE = 2,
   parameter int unsigned R_MODE  = 2
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [ID_W-1:0]       s_awid,
   input  logic [ADDR_W-1:0]     s_awaddr,
   input  logic [LEN_W-1:0]      s_awlen,
   input  logic [AXI_SIZE_W-1:0] s_awsize,
   input  logic [BURST_W-1:0]    s_awburst,
   input  logic                  s_awlock,
   input  logic [CACHE_W-1:0]    s_awcache,
   input  logic [PROT_W-1:0]     s_awprot,
   input  logic                  s_awvalid,
   output logic                  s_awready,
   output logic [ID_W-1:0]       m_awid,
   output logic [ADDR_W-1:0]     m_awaddr,
   output logic [LEN_W-1:0]      m_awlen,
   output logic [AXI_SIZE_W-1:0] m_awsize,
   output logic [BURST_W-1:0]    m_awburst,
   output logic                  m_awlock,
   output logic [CACHE_W-1:0]    m_awcache,
   output logic [PROT_W-1:0]     m_awprot,
   output logic                  m_awvalid,
   input  logic                  m_awready,
   input  logic [DATA_W-1:0]     s_wdata,
   input  logic [DATA_W/8-1:0]   s_wstrb,
   input  logic                  s_wlast,
   input  logic                  s_wvalid,
   output logic                  s_wready,
   output logic [DATA_W-1:0]     m_wdata,
   output logic [DATA_W/8-1:0]   m_wstrb,
   output logic                  m_wlast,
   output logic                  m_wvalid,
   input  logic                  m_wready,
   input  logic [ID_W-1:0]       m_bid,
   input  logic [RESP_W-1:0]     m_bresp,
   input  logic                  m_bvalid,
   output logic                  m_bready,
   output logic [ID_W-1:0]       s_bid,
   output logic [RESP_W-1:0]     s_bresp,
   output logic                  s_bvalid,
   input  logic                  s_bready,
   input  logic [ID_W-1:0]       s_arid,
   input  logic [ADDR_W-1:0]     s_araddr,
   input  logic [LEN_W-1:0]      s_arlen,
   input  logic [AXI_SIZE_W-1:0] s_arsize,
   input  logic [BURST_W-1:0]    s_arburst,
   input  logic                  s_arlock,
   input  logic [CACHE_W-1:0]    s_arcache,
   input  logic [PROT_W-1:0]     s_arprot,
   input  logic                  s_arvalid,
   output logic                  s_arready,
   output logic [ID_W-1:0]       m_arid,
   output logic [ADDR_W-1:0]     m_araddr,
   output logic [LEN_W-1:0]      m_arlen,
   output logic [AXI_SIZE_W-1:0] m_arsize,
   output logic [BURST_W-1:0]    m_arburst,
   output logic                  m_arlock,
   output logic [CACHE_W-1:0]    m_arcache,
   output logic [PROT_W-1:0]     m_arprot,
   output logic                  m_arvalid,
   input  logic                  m_arready,
   input  logic [ID_W-1:0]       m_rid,
   input  logic [DATA_W-1:0]     m_rdata,
   input  logic [RESP_W-1:0]     m_rresp,
   input  logic                  m_rlast,
   input  logic                  m_rvalid,
   output logic                  m_rready,
   output logic [ID_W-1:0]       s_rid,
   output logic [DATA_W-1:0]     s_rdata,
   output logic [RESP_W-1:0]     s_rresp,
   output logic                  s_rlast,
   output logic                  s_rvalid,
   input  logic                  s_rready
);

   localparam int unsigned AX_PW = ax_payload_w(ID_W, ADDR_W, LEN_W);
   localparam int unsigned W_PW  = DATA_W + DATA_W / 8 + 1;
   localparam int unsigned B_PW  = ID_W + RESP_W;
   localparam int unsigned R_PW  = ID_W + DATA_W + RESP_W + 1;

   logic [AX_PW-1:0] aw_dst, ar_dst;
   logic [W_PW-1:0]  w_dst;
   logic [B_PW-1:0]  b_dst;
   logic [R_PW-1:0]  r_dst;

   assign {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot} = aw_dst;
   assign {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot} = ar_dst;
   assign {m_wdata, m_wstrb, m_wlast} = w_dst;
   assign {s_bid, s_bresp}            = b_dst;
   assign {s_rid, s_rdata, s_rresp, s_rlast} = r_dst;

   axi_reg_slice_ch #(.PAYLOAD_W(AX_PW), .MODE(AW_MODE)) u_aw (
      .aclk(aclk), .areset(areset),
      .src_valid(s_awvalid), .src_ready(s_awready),
      .src_data({s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot}),
      .dst_valid(m_awvalid), .dst_ready(m_awready), .dst_data(aw_dst)
   );

   axi_reg_slice_ch #(.PAYLOAD_W(W_PW), .MODE(W_MODE)) u_w (
      .aclk(aclk), .areset(areset),
      .src_valid(s_wvalid), .src_ready(s_wready), .src_data({s_wdata, s_wstrb, s_wlast}),
      .dst_valid(m_wvalid), .dst_ready(m_wready), .dst_data(w_dst)
   );

   // Response channels run slave-to-master, so the m_* side is the source.
   axi_reg_slice_ch #(.PAYLOAD_W(B_PW), .MODE(B_MODE)) u_b (
      .aclk(aclk), .areset(areset),
      .src_valid(m_bvalid), .src_ready(m_bready), .src_data({m_bid, m_bresp}),
      .dst_valid(s_bvalid), .dst_ready(s_bready), .dst_data(b_dst)
   );

   axi_reg_slice_ch #(.PAYLOAD_W(AX_PW), .MODE(AR_MODE)) u_ar (
      .aclk(aclk), .areset(areset),
      .src_valid(s_arvalid), .src_ready(s_arready),
      .src_data({s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot}),
      .dst_valid(m_arvalid), .dst_ready(m_arready), .dst_data(ar_dst)
   );

   axi_reg_slice_ch #(.PAYLOAD_W(R_PW), .MODE(R_MODE)) u_r (
      .aclk(aclk), .areset(areset),
      .src_valid(m_rvalid), .src_ready(m_rready), .src_data({m_rid, m_rdata, m_rresp, m_rlast}),
      .dst_valid(s_rvalid), .dst_ready(s_rready), .dst_data(r_dst)
   );

endmodule

// File: tb/tb_axi_reg_slice.sv
// Bench for axi_reg_slice: AW/W full skid, B/AR forward register, R bypass.
module tb_axi_reg_slice;

   logic aclk = 1'b0;
   logic areset = 1'b1;
   always #5 aclk = ~aclk;

   logic [3:0]  s_awid, m_awid, s_arid, m_arid, m_bid, s_bid, m_rid, s_rid;
   logic [31:0] s_awaddr, m_awaddr, s_araddr, m_araddr;
   logic [7:0]  s_awlen, m_awlen, s_arlen, m_arlen;
   logic [2:0]  s_awsize, m_awsize, s_arsize, m_arsize, s_awprot, m_awprot, s_arprot, m_arprot;
   logic [1:0]  s_awburst, m_awburst, s_arburst, m_arburst, m_bresp, s_bresp, m_rresp, s_rresp;
   logic        s_awlock, m_awlock, s_arlock, m_arlock;
   logic [3:0]  s_awcache, m_awcache, s_arcache, m_arcache;
   logic        s_awvalid, s_awready, m_awvalid, m_awready;
   logic [63:0] s_wdata, m_wdata, m_rdata, s_rdata;
   logic [7:0]  s_wstrb, m_wstrb;
   logic        s_wlast, m_wlast, s_wvalid, s_wready, m_wvalid, m_wready;
   logic        m_bvalid, m_bready, s_bvalid, s_bready;
   logic        s_arvalid, s_arready, m_arvalid, m_arready;
   logic        m_rlast, s_rlast, m_rvalid, m_rready, s_rvalid, s_rready;

   // Channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R.
   logic [127:0] src_pd [5];
   logic         src_vd [5];
   logic         dst_rd [5];
   logic [127:0] src_p [5], dst_p [5];
   logic         src_v [5], src_r [5], dst_v [5], dst_r [5];
   string        chname [5] = '{"aw", "w", "b", "ar", "r"};

   assign {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot} = src_pd[0][56:0];
   assign {s_wdata, s_wstrb, s_wlast} = src_pd[1][72:0];
   assign {m_bid, m_bresp}            = src_pd[2][5:0];
   assign {s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot} = src_pd[3][56:0];
   assign {m_rid, m_rdata, m_rresp, m_rlast} = src_pd[4][70:0];
   assign s_awvalid = src_vd[0];
   assign s_wvalid  = src_vd[1];
   assign m_bvalid  = src_vd[2];
   assign s_arvalid = src_vd[3];
   assign m_rvalid  = src_vd[4];
   assign m_awready = dst_rd[0];
   assign m_wready  = dst_rd[1];
   assign s_bready  = dst_rd[2];
   assign m_arready = dst_rd[3];
   assign s_rready  = dst_rd[4];

   assign src_p[0] = 128'({s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot});
   assign src_p[1] = 128'({s_wdata, s_wstrb, s_wlast});
   assign src_p[2] = 128'({m_bid, m_bresp});
   assign src_p[3] = 128'({s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot});
   assign src_p[4] = 128'({m_rid, m_rdata, m_rresp, m_rlast});
   assign dst_p[0] = 128'({m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot});
   assign dst_p[1] = 128'({m_wdata, m_wstrb, m_wlast});
   assign dst_p[2] = 128'({s_bid, s_bresp});
   assign dst_p[3] = 128'({m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot});
   assign dst_p[4] = 128'({s_rid, s_rdata, s_rresp, s_rlast});
   assign src_v[0] = s_awvalid; assign src_r[0] = s_awready; assign dst_v[0] = m_awvalid; assign dst_r[0] = m_awready;
   assign src_v[1] = s_wvalid;  assign src_r[1] = s_wready;  assign dst_v[1] = m_wvalid;  assign dst_r[1] = m_wready;
   assign src_v[2] = m_bvalid;  assign src_r[2] = m_bready;  assign dst_v[2] = s_bvalid;  assign dst_r[2] = s_bready;
   assign src_v[3] = s_arvalid; assign src_r[3] = s_arready; assign dst_v[3] = m_arvalid; assign dst_r[3] = m_arready;
   assign src_v[4] = m_rvalid;  assign src_r[4] = m_rready;  assign dst_v[4] = s_rvalid;  assign dst_r[4] = s_rready;

   axi_reg_slice #(
      .ID_W(4), .ADDR_W(32), .DATA_W(64), .LEN_W(8),
      .AW_MODE(2), .W_MODE(2), .B_MODE(1), .AR_MODE(1), .R_MODE(0)
   ) dut (
      .aclk(aclk), .areset(areset),
      .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
      .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot),
      .s_awvalid(s_awvalid), .s_awready(s_awready),
      .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
      .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
      .m_awvalid(m_awvalid), .m_awready(m_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
      .s_arvalid(s_arvalid), .s_arready(s_arready),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
      .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
      .m_rvalid(m_rvalid), .m_rready(m_rready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic [127:0] w_beat(input logic [63:0] data, input logic last);
      return 128'({data, 8'hFF, last});
   endfunction

   function automatic logic [31:0] ar_addr(input int i);
      return 32'h1000 + 32'(i) * 32'h40;
   endfunction

   function automatic logic [127:0] ar_beat(input int i);
      return 128'({4'(i), ar_addr(i), 8'd15, 3'd3, 2'd1, 1'b0, 4'd0, 3'd0});
   endfunction

   // Per-channel scoreboard and hold-while-stalled tracking, sampled on the falling edge.
   logic [127:0] sb [5][64];
   int           wr [5] = '{default: 0};
   int           rd [5] = '{default: 0};
   logic         pending [5] = '{default: 1'b0};
   logic [127:0] pend_p [5];
   logic         acc [5] = '{default: 1'b0};

   initial forever begin
      @(negedge aclk);
      for (int c = 0; c < 5; c++) begin
         if (areset) begin
            rd[c]      = wr[c];
            pending[c] = 1'b0;
            acc[c]     = 1'b0;
         end else begin
            acc[c] = src_v[c] && src_r[c];
            if (pending[c]) begin
               check({chname[c], "_hold_valid"}, 128'(dst_v[c]), 128'(1'b1));
               check({chname[c], "_hold_data"}, dst_p[c], pend_p[c]);
            end
            if (acc[c]) begin
               sb[c][wr[c] % 64] = src_p[c];
               wr[c]++;
            end
            if (dst_v[c] && dst_r[c]) begin
               check({chname[c], "_sb_level"}, 128'(wr[c] > rd[c]), 128'(1'b1));
               if (wr[c] > rd[c]) begin
                  check({chname[c], "_order"}, dst_p[c], sb[c][rd[c] % 64]);
                  rd[c]++;
               end
            end
            pending[c] = dst_v[c] && !dst_r[c];
            pend_p[c]  = dst_p[c];
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int c = 0; c < 5; c++) begin
         src_pd[c] = '0;
         src_vd[c] = 1'b0;
         dst_rd[c] = 1'b0;
      end

      // Reset state
      areset = 1'b1;
      tick(); tick();
      check("rst_m_awvalid", 128'(m_awvalid), 128'(1'b0));
      check("rst_s_awready", 128'(s_awready), 128'(1'b0));
      check("rst_m_wvalid",  128'(m_wvalid),  128'(1'b0));
      check("rst_s_wready",  128'(s_wready),  128'(1'b0));
      check("rst_s_bvalid",  128'(s_bvalid),  128'(1'b0));
      check("rst_m_bready",  128'(m_bready),  128'(1'b1));
      check("rst_m_arvalid", 128'(m_arvalid), 128'(1'b0));
      check("rst_s_arready", 128'(s_arready), 128'(1'b1));
      areset = 1'b0;
      tick();
      check("post_rst_s_awready", 128'(s_awready), 128'(1'b1));
      check("post_rst_s_wready",  128'(s_wready),  128'(1'b1));

      // 1: eight back-to-back W beats through the skid buffer
      dst_rd[1] = 1'b1;
      src_vd[1] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         src_pd[1] = w_beat(64'(i), (i == 7));
         tick();
         check("t1_m_wvalid", 128'(m_wvalid), 128'(1'b1));
         check("t1_m_wdata",  128'(m_wdata),  128'(i));
         check("t1_m_wlast",  128'(m_wlast),  128'(i == 7));
         check("t1_s_wready", 128'(s_wready), 128'(1'b1));
      end
      src_vd[1] = 1'b0;
      tick();
      check("t1_drained", 128'(m_wvalid), 128'(1'b0));

      // 2: three-cycle downstream stall fills both skid entries
      src_vd[1] = 1'b1; src_pd[1] = w_beat(64'd20, 1'b0); dst_rd[1] = 1'b1;
      tick();
      check("t2_e0_data", 128'(m_wdata), 128'(20));
      src_pd[1] = w_beat(64'd21, 1'b0); dst_rd[1] = 1'b0;
      tick();
      check("t2_e1_s_wready", 128'(s_wready), 128'(1'b0));
      check("t2_e1_data",     128'(m_wdata),  128'(20));
      src_pd[1] = w_beat(64'd22, 1'b0);
      tick();
      check("t2_e2_s_wready", 128'(s_wready), 128'(1'b0));
      check("t2_e2_data",     128'(m_wdata),  128'(20));
      tick();
      check("t2_e3_data",     128'(m_wdata),  128'(20));
      dst_rd[1] = 1'b1;
      tick();
      check("t2_e4_data",     128'(m_wdata),  128'(21));
      check("t2_e4_s_wready", 128'(s_wready), 128'(1'b1));
      tick();
      check("t2_e5_data",     128'(m_wdata),  128'(22));
      src_pd[1] = w_beat(64'd23, 1'b1);
      tick();
      check("t2_e6_data",     128'(m_wdata),  128'(23));
      check("t2_e6_last",     128'(m_wlast),  128'(1'b1));
      src_vd[1] = 1'b0;
      tick();
      check("t2_drained",     128'(m_wvalid), 128'(1'b0));

      // 3: AR forward register with m_arready toggling
      src_vd[3] = 1'b1; src_pd[3] = ar_beat(0); dst_rd[3] = 1'b1;
      tick();
      check("t3_a0_addr", 128'(m_araddr), 128'(ar_addr(0)));
      src_pd[3] = ar_beat(1);
      tick();
      check("t3_a1_addr", 128'(m_araddr), 128'(ar_addr(1)));
      check("t3_a1_len",  128'(m_arlen),  128'(8'd15));
      src_pd[3] = ar_beat(2); dst_rd[3] = 1'b0;
      #1;
      check("t3_stall_s_arready", 128'(s_arready), 128'(1'b0));
      tick();
      check("t3_stall_addr", 128'(m_araddr), 128'(ar_addr(1)));
      dst_rd[3] = 1'b1;
      #1;
      check("t3_go_s_arready", 128'(s_arready), 128'(1'b1));
      tick();
      check("t3_a2_addr", 128'(m_araddr), 128'(ar_addr(2)));
      src_pd[3] = ar_beat(3); dst_rd[3] = 1'b0;
      tick();
      check("t3_stall2_addr",  128'(m_araddr),  128'(ar_addr(2)));
      check("t3_stall2_valid", 128'(m_arvalid), 128'(1'b1));
      dst_rd[3] = 1'b1;
      tick();
      check("t3_a3_addr", 128'(m_araddr), 128'(ar_addr(3)));
      src_vd[3] = 1'b0;
      tick();
      check("t3_drained", 128'(m_arvalid), 128'(1'b0));

      // 4: R bypass is purely combinational in both directions
      src_vd[4] = 1'b1;
      src_pd[4] = 128'({4'd5, 64'hDEADBEEF01234567, 2'd2, 1'b1});
      dst_rd[4] = 1'b0;
      #1;
      check("t4_s_rpayload", 128'({s_rid, s_rdata, s_rresp, s_rlast}),
            128'({4'd5, 64'hDEADBEEF01234567, 2'd2, 1'b1}));
      check("t4_s_rvalid", 128'(s_rvalid), 128'(1'b1));
      check("t4_m_rready_lo", 128'(m_rready), 128'(1'b0));
      dst_rd[4] = 1'b1;
      #1;
      check("t4_m_rready_hi", 128'(m_rready), 128'(1'b1));
      tick();
      src_vd[4] = 1'b0;
      #1;
      check("t4_s_rvalid_off", 128'(s_rvalid), 128'(1'b0));

      // 5: reset while the W skid buffer holds two beats
      dst_rd[1] = 1'b0; src_vd[1] = 1'b1; src_pd[1] = w_beat(64'd30, 1'b0);
      tick();
      src_pd[1] = w_beat(64'd31, 1'b1);
      tick();
      src_vd[1] = 1'b0;
      check("t5_full_s_wready", 128'(s_wready), 128'(1'b0));
      areset = 1'b1;
      tick();
      check("t5_rst_m_wvalid", 128'(m_wvalid), 128'(1'b0));
      check("t5_rst_s_wready", 128'(s_wready), 128'(1'b0));
      areset = 1'b0;
      dst_rd[1] = 1'b1;
      tick();
      check("t5_post_s_wready", 128'(s_wready), 128'(1'b1));
      check("t5_post_m_wvalid", 128'(m_wvalid), 128'(1'b0));
      tick();
      check("t5_no_stale", 128'(m_wvalid), 128'(1'b0));

      // 6: random valid/ready on all channels, checked by the scoreboard
      for (int cyc = 0; cyc < 10000; cyc++) begin
         tick();
         for (int c = 0; c < 5; c++) begin
            if (!src_vd[c] || acc[c]) begin
               src_vd[c] = ($urandom_range(3) != 0);
               src_pd[c] = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            dst_rd[c] = ($urandom_range(3) != 0);
         end
      end
      for (int cyc = 0; cyc < 16; cyc++) begin
         tick();
         for (int c = 0; c < 5; c++) begin
            if (acc[c]) src_vd[c] = 1'b0;
            dst_rd[c] = 1'b1;
         end
      end
      tick();
      for (int c = 0; c < 5; c++) begin
         check({chname[c], "_drained"}, 128'(rd[c]), 128'(wr[c]));
         check({chname[c], "_idle"}, 128'(dst_v[c]), 128'(1'b0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
